// File: rtl/div_bcd_conv.sv
// Sequential binary-to-packed-BCD converter (double dabble), one input bit per clock.
// Accepts a value from the divider on start and pulses done with the digits and significant digit count.
module div_bcd_conv #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [3:0]            ndigits
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    bin_sr;
  logic [4*DIGITS-1:0] bcd_sr;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_next;
  logic [CW-1:0]       cnt;
  logic                last_shift;
  logic [3:0]          nd_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign last_shift = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Add-3 is applied per digit with no carry between digits; sizing keeps every digit below 16.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_next = {bcd_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};

  // Significant digit count of the value about to be published; zero still counts as one digit.
  always_comb begin
    nd_next = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_next[4*i +: 4] != 4'd0) begin
        nd_next = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      ndigits <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_sr <= bcd_next;
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
          if (last_shift) begin
            bcd_out <= bcd_next;
            ndigits <= nd_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_conv.sv
// Self-checking bench for div_bcd_conv: fixed vectors, random values against a decimal model,
// and hand-written sequences for held start, mid-conversion reset and back-to-back chaining.
module tb_div_bcd_conv;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [3:0]          ndigits;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [3:0]  nd;
  } vec_t;

  vec_t tbl[10];

  div_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ndigits (ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: peel digits off with /10 and %10.
  task automatic model(input logic [31:0] v, output logic [39:0] bcd, output logic [3:0] nd);
    longint x;
    longint d;
    x   = longint'(v);
    bcd = '0;
    nd  = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      d = x % 10;
      bcd[4*i +: 4] = d[3:0];
      if (d != 0) nd = 4'(i + 1);
      x = x / 10;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Runs one conversion; returns the result, edges from accept to done, and whether outputs held steady.
  task automatic applyStimulus(input logic [31:0] v, output logic [39:0] bcd, output logic [3:0] nd,
                               output int lat);
    logic [39:0] held_bcd;
    logic [3:0]  held_nd;
    bit          stable;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    held_bcd = bcd_out;
    held_nd  = ndigits;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = $urandom;
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    lat    = 0;
    stable = 1'b1;
    while (!done && lat < 100) begin
      if (bcd_out !== held_bcd || ndigits !== held_nd) stable = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("outputs_stable_during_conv", 64'(stable), 64'd1);
    bcd = bcd_out;
    nd  = ndigits;
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", 64'(done), 64'd0);
    checkOutput("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [39:0] got_bcd;
    logic [3:0]  got_nd;
    logic [39:0] exp_bcd;
    logic [3:0]  exp_nd;
    logic [31:0] rv;
    int          lat;
    int          ndone;

    checks   = 0;
    failures = 0;

    tbl[0] = '{32'd14,          40'h00_0000_0014, 4'd2};
    tbl[1] = '{32'd0,           40'h00_0000_0000, 4'd1};
    tbl[2] = '{32'd1,           40'h00_0000_0001, 4'd1};
    tbl[3] = '{32'hFFFF_FFFF,   40'h42_9496_7295, 4'd10};
    tbl[4] = '{32'd1000000000,  40'h10_0000_0000, 4'd10};
    tbl[5] = '{32'd70,          40'h00_0000_0070, 4'd2};
    tbl[6] = '{32'd9,           40'h00_0000_0009, 4'd1};
    tbl[7] = '{32'd10,          40'h00_0000_0010, 4'd2};
    tbl[8] = '{32'd999999999,   40'h09_9999_9999, 4'd9};
    tbl[9] = '{32'd4294967290,  40'h42_9496_7290, 4'd10};

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #12;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_bcd", 64'(bcd_out), 64'd0);
    checkOutput("reset_ndigits", 64'(ndigits), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].bin, got_bcd, got_nd, lat);
      checkOutput($sformatf("vec%0d_bcd", i), 64'(got_bcd), 64'(tbl[i].bcd));
      checkOutput($sformatf("vec%0d_ndigits", i), 64'(got_nd), 64'(tbl[i].nd));
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(WIDTH));
    end

    for (int i = 0; i < 20; i++) begin
      rv = $urandom;
      if (i % 4 == 1) rv = rv >> ($urandom_range(31, 4));
      model(rv, exp_bcd, exp_nd);
      applyStimulus(rv, got_bcd, got_nd, lat);
      checkOutput($sformatf("rand%0d_bcd", i), 64'(got_bcd), 64'(exp_bcd));
      checkOutput($sformatf("rand%0d_ndigits", i), 64'(got_nd), 64'(exp_nd));
    end

    // Start held for five cycles with bin_in changed mid-way: one conversion of the original value.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 32'd12345;
    ndone  = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (c == 1) bin_in = 32'd99;
    end
    start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    checkOutput("held_start_done_count", 64'(ndone), 64'd1);
    checkOutput("held_start_bcd", 64'(bcd_out), 64'h12345);
    checkOutput("held_start_ndigits", 64'(ndigits), 64'd5);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 32'd4000000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    checkOutput("midreset_bcd", 64'(bcd_out), 64'd0);
    checkOutput("midreset_ndigits", 64'(ndigits), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    checkOutput("midreset_no_done", 64'(ndone), 64'd0);
    applyStimulus(32'd5, got_bcd, got_nd, lat);
    checkOutput("post_reset_bcd", 64'(got_bcd), 64'h5);
    checkOutput("post_reset_ndigits", 64'(got_nd), 64'd1);
    checkOutput("post_reset_latency", 64'(lat), 64'(WIDTH));

    // Divider chain: 100/7 quotient, then 70/150 remainder in the first IDLE cycle.
    applyStimulus(32'd14, got_bcd, got_nd, lat);
    checkOutput("chain_q_bcd", 64'(got_bcd), 64'h14);
    checkOutput("chain_q_latency", 64'(lat), 64'(WIDTH));
    applyStimulus(32'd70, got_bcd, got_nd, lat);
    checkOutput("chain_r_bcd", 64'(got_bcd), 64'h70);
    checkOutput("chain_r_ndigits", 64'(got_nd), 64'd2);
    checkOutput("chain_r_latency", 64'(lat), 64'(WIDTH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
